// File: rtl/psk_demod_if.sv
// AXI-Stream style output bundle for psk_demod: one decided symbol per beat.
interface psk_demod_if #(
  parameter int BYTES = 1
);
  logic [BYTES*8-1:0] m_tdata;
  logic               m_tvalid;
  logic               m_tready;
  logic               m_tlast;
  logic               m_tuser;

  modport master (
    output m_tdata,
    output m_tvalid,
    output m_tlast,
    output m_tuser,
    input  m_tready
  );

  modport slave (
    input  m_tdata,
    input  m_tvalid,
    input  m_tlast,
    input  m_tuser,
    output m_tready
  );
endinterface

// File: rtl/psk_demod.sv
// Integrate-and-dump BPSK/QPSK hard-decision detector, one AXIS beat per symbol.
// A strobe arriving mid-symbol aborts the partial sum; a decision arriving while a beat is held is dropped.
module psk_demod #(
  parameter int WIDTH    = 12,
  parameter int BYTES    = 1,
  parameter int LOG2_SPS = 4
) (
  input  logic                    clk_16M384,
  input  logic                    rstn_16M384,
  input  logic signed [WIDTH-1:0] in_I,
  input  logic signed [WIDTH-1:0] in_Q,
  input  logic                    in_vld,
  input  logic                    in_sym_start,
  input  logic                    in_is_bpsk,
  input  logic                    in_last,
  psk_demod_if.master             m_axis,
  output logic                    sync_err,
  output logic                    overflow
);

  localparam int AW = WIDTH + LOG2_SPS;
  localparam int DW = BYTES * 8;
  localparam logic [LOG2_SPS-1:0] CNT_ZERO = '0;
  localparam logic [LOG2_SPS-1:0] CNT_LAST = '1;
  localparam logic [LOG2_SPS-1:0] CNT_ONE  = {{(LOG2_SPS-1){1'b0}}, 1'b1};

  // BPSK adds I and Q one bit wider so two full-scale negative sums cannot wrap; zero decides 1.
  function automatic logic [1:0] decide(input logic [AW-1:0] sum_i,
                                        input logic [AW-1:0] sum_q,
                                        input logic          bpsk);
    logic [AW:0] both;
    both = {sum_i[AW-1], sum_i} + {sum_q[AW-1], sum_q};
    if (bpsk) begin
      decide = {~both[AW], ~both[AW]};
    end else begin
      decide = {~sum_i[AW-1], ~sum_q[AW-1]};
    end
  endfunction

  logic [LOG2_SPS-1:0] cnt_r;
  logic [AW-1:0]       acc_i_r;
  logic [AW-1:0]       acc_q_r;
  logic                all_vld_r;
  logic                bpsk_r;

  logic [LOG2_SPS-1:0] eff_cnt_s;
  logic                first_s;
  logic                last_s;
  logic                abort_s;
  logic [AW-1:0]       ext_i_s;
  logic [AW-1:0]       ext_q_s;
  logic [AW-1:0]       acc_i_s;
  logic [AW-1:0]       acc_q_s;
  logic                all_vld_s;
  logic                bpsk_s;
  logic [1:0]          dec_s;
  logic                load_s;
  logic                busy_s;

  // Current-sample view: effective position, running sums including this sample, decision.
  always_comb begin
    eff_cnt_s = cnt_r;
    ext_i_s   = {{LOG2_SPS{in_I[WIDTH-1]}}, in_I};
    ext_q_s   = {{LOG2_SPS{in_Q[WIDTH-1]}}, in_Q};
    if (in_sym_start) begin
      eff_cnt_s = CNT_ZERO;
    end else begin
      eff_cnt_s = cnt_r;
    end
    first_s = (eff_cnt_s == CNT_ZERO);
    last_s  = (eff_cnt_s == CNT_LAST);
    abort_s = in_sym_start && (cnt_r != CNT_ZERO);
    if (first_s) begin
      acc_i_s   = ext_i_s;
      acc_q_s   = ext_q_s;
      all_vld_s = in_vld;
      bpsk_s    = in_is_bpsk;
    end else begin
      acc_i_s   = acc_i_r + ext_i_s;
      acc_q_s   = acc_q_r + ext_q_s;
      all_vld_s = all_vld_r & in_vld;
      bpsk_s    = bpsk_r;
    end
    dec_s  = decide(acc_i_s, acc_q_s, bpsk_s);
    load_s = last_s & all_vld_s;
    busy_s = m_axis.m_tvalid & ~m_axis.m_tready;
  end

  // Sample counter, accumulators and per-symbol validity/mode state.
  always_ff @(posedge clk_16M384 or negedge rstn_16M384) begin
    if (!rstn_16M384) begin
      cnt_r     <= CNT_ZERO;
      acc_i_r   <= '0;
      acc_q_r   <= '0;
      all_vld_r <= 1'b0;
      bpsk_r    <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      cnt_r     <= eff_cnt_s + CNT_ONE;
      acc_i_r   <= acc_i_s;
      acc_q_r   <= acc_q_s;
      all_vld_r <= all_vld_s;
      bpsk_r    <= bpsk_s;
      sync_err  <= abort_s;
    end
  end

  // Single output register: a held beat wins over a new decision, which then sets overflow.
  always_ff @(posedge clk_16M384 or negedge rstn_16M384) begin
    if (!rstn_16M384) begin
      m_axis.m_tvalid <= 1'b0;
      m_axis.m_tdata  <= '0;
      m_axis.m_tlast  <= 1'b0;
      m_axis.m_tuser  <= 1'b0;
      overflow        <= 1'b0;
    end else if (load_s && busy_s) begin
      overflow <= 1'b1;
    end else if (load_s) begin
      m_axis.m_tvalid <= 1'b1;
      m_axis.m_tdata  <= {{(DW-2){1'b0}}, dec_s};
      m_axis.m_tlast  <= in_last;
      m_axis.m_tuser  <= bpsk_s;
    end else if (m_axis.m_tvalid && m_axis.m_tready) begin
      m_axis.m_tvalid <= 1'b0;
    end else begin
      m_axis.m_tvalid <= m_axis.m_tvalid;
    end
  end

endmodule

// File: tb/tb_psk_demod.sv
// Self-checking bench for psk_demod: scoreboard of expected beats popped on each AXIS handshake.
module tb_psk_demod;
  localparam int WIDTH    = 12;
  localparam int BYTES    = 1;
  localparam int LOG2_SPS = 4;
  localparam int SPS      = 16;

  logic                    clk_16M384  = 1'b0;
  logic                    rstn_16M384 = 1'b1;
  logic signed [WIDTH-1:0] in_I = '0;
  logic signed [WIDTH-1:0] in_Q = '0;
  logic                    in_vld = 1'b0;
  logic                    in_sym_start = 1'b0;
  logic                    in_is_bpsk = 1'b0;
  logic                    in_last = 1'b0;
  logic                    sync_err;
  logic                    overflow;

  psk_demod_if #(.BYTES(BYTES)) axis ();

  psk_demod #(.WIDTH(WIDTH), .BYTES(BYTES), .LOG2_SPS(LOG2_SPS)) dut (
    .clk_16M384  (clk_16M384),
    .rstn_16M384 (rstn_16M384),
    .in_I        (in_I),
    .in_Q        (in_Q),
    .in_vld      (in_vld),
    .in_sym_start(in_sym_start),
    .in_is_bpsk  (in_is_bpsk),
    .in_last     (in_last),
    .m_axis      (axis),
    .sync_err    (sync_err),
    .overflow    (overflow)
  );

  always #30 clk_16M384 = ~clk_16M384;

  // Expected beat = {tlast, tuser, tdata}
  logic [9:0] exp_q[$];
  logic [9:0] got_b;
  logic [9:0] exp_b;
  int n_checks = 0;
  int n_fail   = 0;
  int n_beats  = 0;
  int sync_hi  = 0;

  // Scoreboard monitor: a beat transfers on the next rising edge when valid & ready are seen here.
  always @(negedge clk_16M384) begin
    if (rstn_16M384 && axis.m_tvalid && axis.m_tready) begin
      n_beats++;
      n_checks++;
      got_b = {axis.m_tlast, axis.m_tuser, axis.m_tdata};
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL beat_unexpected: got %h, required no beat", got_b);
      end else begin
        exp_b = exp_q.pop_front();
        if (got_b !== exp_b) begin
          n_fail++;
          $display("FAIL beat_value: got {last,user,data}=%h, required %h", got_b, exp_b);
        end
      end
    end
    if (rstn_16M384 && sync_err === 1'b1) sync_hi++;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, required finish within 1 ms");
    $fatal(1, "timeout");
  end

  task automatic send_sym(input int i_v, input int q_v, input logic bpsk, input logic last,
                          input logic [15:0] vmask, output logic pre_vld);
    pre_vld = 1'b0;
    for (int k = 0; k < SPS; k++) begin
      in_I         = WIDTH'(i_v);
      in_Q         = WIDTH'(q_v);
      in_vld       = vmask[k];
      in_sym_start = (k == 0);
      in_is_bpsk   = bpsk;
      in_last      = (k == SPS - 1) ? last : 1'b0;
      if (k == SPS - 1) pre_vld = axis.m_tvalid;
      @(posedge clk_16M384); #1;
    end
    in_vld = 1'b0; in_sym_start = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_partial(input int i_v, input int q_v, input int n);
    for (int k = 0; k < n; k++) begin
      in_I = WIDTH'(i_v); in_Q = WIDTH'(q_v); in_vld = 1'b1; in_sym_start = (k == 0);
      @(posedge clk_16M384); #1;
    end
    in_vld = 1'b0; in_sym_start = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_16M384); #1;
    end
  endtask

  task automatic test_reset();
    axis.m_tready = 1'b0;
    #1 rstn_16M384 = 1'b0;
    #5;
    n_checks++;
    if ({axis.m_tvalid, axis.m_tdata, axis.m_tlast, axis.m_tuser} !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_axis: got %b, required 0", {axis.m_tvalid, axis.m_tdata, axis.m_tlast, axis.m_tuser});
    end
    n_checks++;
    if ({sync_err, overflow} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, required 00", {sync_err, overflow});
    end
    @(posedge clk_16M384); @(posedge clk_16M384); #1;
    rstn_16M384 = 1'b1;
  endtask

  task automatic test_qpsk();
    int         iv[4] = '{100, -100, 100, -100};
    int         qv[4] = '{-100, 100, 100, -100};
    logic [1:0] eb[4] = '{2'b10, 2'b01, 2'b11, 2'b00};
    logic       pre;
    axis.m_tready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      exp_q.push_back({1'b0, 1'b0, 6'b0, eb[s]});
      send_sym(iv[s], qv[s], 1'b0, 1'b0, 16'hFFFF, pre);
      n_checks++;
      if (pre !== 1'b0 || axis.m_tvalid !== 1'b1) begin
        n_fail++;
        $display("FAIL qpsk_latency sym%0d: valid before/after edge %b/%b, required 0/1", s, pre, axis.m_tvalid);
      end
      n_checks++;
      if (axis.m_tdata[1:0] !== eb[s]) begin
        n_fail++;
        $display("FAIL qpsk_data sym%0d: got %b, required %b", s, axis.m_tdata[1:0], eb[s]);
      end
    end
  endtask

  task automatic test_bpsk();
    logic pre;
    exp_q.push_back({1'b0, 1'b1, 8'h00});
    send_sym(-50, -50, 1'b1, 1'b0, 16'hFFFF, pre);
    n_checks++;
    if (axis.m_tuser !== 1'b1 || axis.m_tdata[1:0] !== 2'b00) begin
      n_fail++;
      $display("FAIL bpsk_neg: got user=%b data=%b, required 1/00", axis.m_tuser, axis.m_tdata[1:0]);
    end
    exp_q.push_back({1'b0, 1'b1, 8'h03});
    send_sym(3, -3, 1'b1, 1'b0, 16'hFFFF, pre);
    n_checks++;
    if (axis.m_tuser !== 1'b1 || axis.m_tdata[1:0] !== 2'b11) begin
      n_fail++;
      $display("FAIL bpsk_zero: got user=%b data=%b, required 1/11", axis.m_tuser, axis.m_tdata[1:0]);
    end
  endtask

  task automatic test_vld_drop();
    int   s0, b0;
    logic pre;
    idle_cycles(SPS);
    s0 = sync_hi; b0 = n_beats;
    exp_q.push_back({1'b0, 1'b0, 8'h03});
    send_sym(100, 100, 1'b0, 1'b0, 16'hFFFF, pre);
    send_sym(-100, 100, 1'b0, 1'b0, 16'hFF7F, pre);
    exp_q.push_back({1'b0, 1'b0, 8'h00});
    send_sym(-100, -100, 1'b0, 1'b0, 16'hFFFF, pre);
    idle_cycles(SPS);
    n_checks++;
    if (n_beats - b0 !== 2) begin
      n_fail++;
      $display("FAIL vld_drop_beats: got %0d beats, required 2", n_beats - b0);
    end
    n_checks++;
    if (sync_hi !== s0) begin
      n_fail++;
      $display("FAIL vld_drop_sync: got %0d sync_err cycles, required 0", sync_hi - s0);
    end
  endtask

  task automatic test_abort();
    int   s0;
    logic pre;
    s0 = sync_hi;
    send_partial(-300, 300, 9);
    exp_q.push_back({1'b0, 1'b0, 8'h02});
    send_sym(100, -100, 1'b0, 1'b0, 16'hFFFF, pre);
    n_checks++;
    if (sync_hi - s0 !== 1) begin
      n_fail++;
      $display("FAIL abort_sync_pulse: got %0d high cycles, required 1", sync_hi - s0);
    end
    n_checks++;
    if (axis.m_tvalid !== 1'b1 || axis.m_tdata[1:0] !== 2'b10) begin
      n_fail++;
      $display("FAIL abort_data: got valid=%b data=%b, required 1/10", axis.m_tvalid, axis.m_tdata[1:0]);
    end
    idle_cycles(SPS);
  endtask

  task automatic test_backpressure();
    logic pre;
    axis.m_tready = 1'b0;
    exp_q.push_back({1'b0, 1'b0, 8'h03});
    send_sym(100, 100, 1'b0, 1'b0, 16'hFFFF, pre);
    n_checks++;
    if (axis.m_tvalid !== 1'b1 || axis.m_tdata !== 8'h03 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_first: got valid=%b data=%h ovf=%b, required 1/03/0", axis.m_tvalid, axis.m_tdata, overflow);
    end
    send_sym(-100, -100, 1'b0, 1'b0, 16'hFFFF, pre);
    n_checks++;
    if (axis.m_tvalid !== 1'b1 || axis.m_tdata !== 8'h03 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_held: got valid=%b data=%h ovf=%b, required 1/03/1", axis.m_tvalid, axis.m_tdata, overflow);
    end
    axis.m_tready = 1'b1;
    idle_cycles(1);
    n_checks++;
    if (axis.m_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: got valid=%b, required 0", axis.m_tvalid);
    end
    idle_cycles(SPS - 1);
  endtask

  task automatic test_fullscale_reset();
    logic pre;
    exp_q.push_back({1'b1, 1'b0, 8'h00});
    send_sym(-2048, -2048, 1'b0, 1'b1, 16'hFFFF, pre);
    n_checks++;
    if (axis.m_tlast !== 1'b1 || axis.m_tdata[1:0] !== 2'b00) begin
      n_fail++;
      $display("FAIL fs_qpsk: got last=%b data=%b, required 1/00", axis.m_tlast, axis.m_tdata[1:0]);
    end
    exp_q.push_back({1'b0, 1'b1, 8'h00});
    send_sym(-2048, -2048, 1'b1, 1'b0, 16'hFFFF, pre);
    n_checks++;
    if (axis.m_tdata[1:0] !== 2'b00) begin
      n_fail++;
      $display("FAIL fs_bpsk: got data=%b, required 00", axis.m_tdata[1:0]);
    end
    idle_cycles(1);
    axis.m_tready = 1'b0;
    idle_cycles(SPS - 1);
    send_sym(100, 100, 1'b0, 1'b0, 16'hFFFF, pre);
    n_checks++;
    if (axis.m_tvalid !== 1'b1 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_state: got valid=%b ovf=%b, required 1/1", axis.m_tvalid, overflow);
    end
    send_partial(50, 50, 5);
    #10 rstn_16M384 = 1'b0;
    #1;
    n_checks++;
    if ({axis.m_tvalid, axis.m_tdata, axis.m_tlast, axis.m_tuser, sync_err, overflow} !== 13'b0) begin
      n_fail++;
      $display("FAIL async_reset: got %b, required all 0",
               {axis.m_tvalid, axis.m_tdata, axis.m_tlast, axis.m_tuser, sync_err, overflow});
    end
    @(posedge clk_16M384); @(posedge clk_16M384); #1;
    rstn_16M384   = 1'b1;
    axis.m_tready = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 8'h01});
    send_sym(-100, 100, 1'b0, 1'b0, 16'hFFFF, pre);
    n_checks++;
    if (axis.m_tvalid !== 1'b1 || axis.m_tdata !== 8'h01) begin
      n_fail++;
      $display("FAIL post_reset: got valid=%b data=%h, required 1/01", axis.m_tvalid, axis.m_tdata);
    end
    idle_cycles(2);
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d beats outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_qpsk();
    test_bpsk();
    test_vld_drop();
    test_abort();
    test_backpressure();
    test_fullscale_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/psk_demod.md
Name: psk_demod

Overview:
- Baseband BPSK/QPSK symbol detector for the receive path, in the 16.384 MHz domain.
- Takes carrier-stripped I/Q samples, 16 per symbol (1.024 Msym/s), and integrates them over each symbol period under a symbol-start strobe (integrate-and-dump).
- Makes hard bit decisions with the same bit mapping as the transmit modulator.
- Emits one AXIS beat per symbol: bits in tdata[1:0], is_bpsk in tuser.

Parameters:
- WIDTH, 12, signed sample width of in_I/in_Q.
- BYTES, 1, output tdata width in bytes (minimum 1).
- LOG2_SPS, 4, log2 of samples per symbol (SPS = 16).

Ports:
- clk_16M384  in  1  sample clock.
- rstn_16M384  in  1  asynchronous active-low reset.
- in_I  in  WIDTH  signed baseband I sample.
- in_Q  in  WIDTH  signed baseband Q sample.
- in_vld  in  1  sample valid.
- in_sym_start  in  1  current sample is sample 0 of a symbol.
- in_is_bpsk  in  1  mode, sampled at sample 0.
- in_last  in  1  frame-end marker, sampled at sample SPS-1.
- m_tdata  out  BYTES*8  decided bits.
- m_tvalid  out  1  AXIS valid.
- m_tready  in  1  AXIS ready.
- m_tlast  out  1  last symbol of frame.
- m_tuser  out  1  is_bpsk of the symbol.
- sync_err  out  1  one-cycle pulse: symbol aborted.
- overflow  out  1  sticky: decision dropped because the output was full.

Behaviour:
- Reset (async assert, sync release): cnt=0, accumulators=0, all_vld=0, m_tvalid=0, m_tdata=0, m_tlast=0, m_tuser=0, sync_err=0, overflow=0.
- Sample counter cnt (LOG2_SPS bits) advances every clock, wraps SPS-1 -> 0.
- in_sym_start=1 forces cnt=0 for the current sample.
- Accumulators acc_I and acc_Q are signed, WIDTH+LOG2_SPS bits, sign-extended adds, no saturation needed.
- Sample 0 (cnt==0 or in_sym_start):
  - acc <= sample (load, not add).
  - all_vld <= in_vld.
  - Capture is_bpsk.
  - Next cnt = 1.
- Samples 1..SPS-1: acc <= acc + sample; all_vld <= all_vld & in_vld.
- Sample SPS-1 completes the symbol. Decision formed from the final sums, including this sample:
  - QPSK: b1 = (sum_I >= 0), b0 = (sum_Q >= 0).
  - BPSK: b1 = (sum_I + sum_Q >= 0), computed WIDTH+LOG2_SPS+1 bits wide; b0 = b1.
  - A zero sum decides 1.
- Output load: registered the edge after sample SPS-1 is presented.
  - m_tdata = {zeros, b1, b0}; m_tlast = in_last at sample SPS-1; m_tuser = captured is_bpsk.
  - Latency: m_tvalid rises 1 cycle after the sample SPS-1 clock edge.
- A symbol is emitted only if all_vld is still 1 including sample SPS-1. Otherwise it is silently dropped: no beat, no error.
- in_sym_start while cnt != 0 aborts the partial symbol:
  - No output; sync_err pulses 1 cycle.
  - The new symbol starts from the current sample.
- AXIS: single output register.
  - Beat completes when m_tvalid & m_tready; m_tvalid then clears unless a new decision loads on the same edge (load wins, m_tvalid stays 1).
  - m_tdata/m_tlast/m_tuser hold stable while m_tvalid & !m_tready.
  - New decision while m_tvalid & !m_tready: new decision is discarded, held beat is kept, overflow <= 1 (sticky until reset).
- m_tvalid does not depend on m_tready combinationally.
- Reset mid-symbol: partial symbol lost, pending beat lost, restart at cnt=0.

Test Plan:
- QPSK, sym_start every 16 cycles, 4 symbols of I/Q=(+100,-100), (-100,+100), (+100,+100), (-100,-100), m_tready=1 -> tdata[1:0] = 2'b10, 01, 11, 00; m_tuser=0; each m_tvalid rises 1 cycle after the 16th sample edge.
- BPSK, I=Q=-50 for one symbol, then I=+3, Q=-3 for one symbol (sum 0) -> tdata[1:0] = 00, then 11; m_tuser=1.
- in_vld low on sample 7 of symbol 2 of 3 -> 2 beats only; sync_err never pulses.
- in_sym_start asserted at cnt=9 -> sync_err 1-cycle pulse; next beat holds the decision of the 16 samples starting at the strobe.
- m_tready held 0 over 2 symbols (+100, then -100 on I and Q) -> m_tdata stays 2'b11 and stable; overflow=1 after the second decision; after ready rises, one beat 2'b11 is delivered and m_tvalid falls.
- Full-scale I=Q=-2048 (WIDTH=12) for 16 samples -> no wrap, decision 00; m_tlast=1 when in_last=1 at sample 15; async reset asserted mid-symbol -> all outputs 0 immediately.
